step_sequencer: RTL and testbench

Programmable 16-step, 3-channel note sequencer that drives the note and enable inputs of the two square channels and the triangle channel, replacing the hard-coded demo pattern. Holds a writable pattern memory, a step-rate timer, a play/stop/restart state machine, and the free-running note clock shared by the channel effects. Sits between the board controls and the channel instances, ahead of the mixer.

---
 rtl/step_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_step_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer
// Programmable 16-step, 3-channel note sequencer. It drives the note and
// enable inputs of the two square channels and the triangle channel.
// The block contains a writable pattern memory, a step-rate timer, a
// play/stop/restart state machine, and a free-running note clock that the
// channel effects share.
//
// Parameters:
//   TICK_DIV     - clk50mhz cycles per sequencer step (>= 2)
//   NOTE_CLK_DIV - clk50mhz cycles per note_clk half-period (>= 1)
//
// Ports:
//   clk50mhz, rst_n             system clock; asynchronous active-low reset
//   play, stop, restart         level controls (stop > restart > advance)
//   seq_len[3:0]                index of the last step played
//   mute[2:0]                   per-channel mute (bit0 sq1, bit1 sq2, bit2 tri)
//   wr_en, wr_step, wr_ch,
//   wr_gate, wr_note            pattern write port; one entry per cycle
//                               while wr_en is high; wr_ch=3 is ignored
//   note_sq1/sq2/tri[5:0]       current note per channel
//   en_sq1/sq2/tri              channel enables (playing & gate & ~mute)
//   step_idx[3:0]               step currently presented
//   step_pulse                  one-cycle strobe on every step load
//   beat_led                    toggles on every step load
//   note_clk                    free-running tempo clock
//   playing                     high in PLAYING (this is the exposed FSM state)
module step_sequencer #(
   parameter int TICK_DIV     = 6000000,
   parameter int NOTE_CLK_DIV = 3187500
) (
   input  logic       clk50mhz,
   input  logic       rst_n,
   input  logic       play,
   input  logic       stop,
   input  logic       restart,
   input  logic [3:0] seq_len,
   input  logic [2:0] mute,
   input  logic       wr_en,
   input  logic [3:0] wr_step,
   input  logic [1:0] wr_ch,
   input  logic       wr_gate,
   input  logic [5:0] wr_note,
   output logic [5:0] note_sq1,
   output logic [5:0] note_sq2,
   output logic [5:0] note_tri,
   output logic       en_sq1,
   output logic       en_sq2,
   output logic       en_tri,
   output logic [3:0] step_idx,
   output logic       step_pulse,
   output logic       beat_led,
   output logic       note_clk,
   output logic       playing
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int NW = $clog2(NOTE_CLK_DIV + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [NW-1:0] NCLK_LAST = NW'(NOTE_CLK_DIV - 1);

   typedef enum logic {STOPPED = 1'b0, PLAYING = 1'b1} state_t;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic [NW-1:0] nclk_cnt;
   logic [2:0]    gate;
   logic [6:0]    mem [16][3];   // {gate, note[5:0]}

   logic          do_load;
   logic [3:0]    load_idx;
   logic [3:0]    next_idx;
   logic [6:0]    ent_sq1, ent_sq2, ent_tri;

   // Pattern memory. The write port is a plain strobe: every cycle with wr_en
   // high writes one entry, and there is no back-pressure. A load on the same
   // edge reads the old contents, so a write never bypasses into the outputs.
   always_ff @(posedge clk50mhz or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 16; s++)
            for (int c = 0; c < 3; c++)
               mem[s][c] <= '0;
      end else if (wr_en && wr_ch != 2'd3) begin
         mem[wr_step][wr_ch] <= {wr_gate, wr_note};
      end
   end

   // Decide whether this edge loads a step, and which one.
   always_comb begin
      do_load  = 1'b0;
      load_idx = step_idx;
      // Reducing seq_len below step_idx mid-play makes the next advance wrap.
      next_idx = (step_idx >= seq_len) ? 4'd0 : step_idx + 4'd1;
      case (state)
         STOPPED: begin
            if (play && !stop) begin
               do_load  = 1'b1;
               load_idx = restart ? 4'd0 : step_idx;
            end
         end
         PLAYING: begin
            if (!stop) begin
               if (restart) begin
                  do_load  = 1'b1;
                  load_idx = 4'd0;
               end else if (tick_cnt == TICK_LAST) begin
                  do_load  = 1'b1;
                  load_idx = next_idx;
               end
            end
         end
         default: ;
      endcase
   end

   assign ent_sq1 = mem[load_idx][0];
   assign ent_sq2 = mem[load_idx][1];
   assign ent_tri = mem[load_idx][2];

   // Play/stop state machine together with the step timer and the registered outputs.
   always_ff @(posedge clk50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= STOPPED;
         tick_cnt   <= '0;
         step_idx   <= '0;
         note_sq1   <= '0;
         note_sq2   <= '0;
         note_tri   <= '0;
         gate       <= '0;
         beat_led   <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         case (state)
            STOPPED: begin
               if (play && !stop) begin
                  state    <= PLAYING;
                  tick_cnt <= '0;
               end else if (restart && !stop) begin
                  step_idx <= '0;
                  tick_cnt <= '0;
               end
            end
            PLAYING: begin
               if (stop) begin
                  // Pause: notes, step_idx and tick_cnt hold, and the gates drop.
                  state <= STOPPED;
                  gate  <= '0;
               end else if (restart || tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            default: state <= STOPPED;
         endcase

         if (do_load) begin
            step_idx   <= load_idx;
            step_pulse <= 1'b1;
            beat_led   <= ~beat_led;
            gate       <= {ent_tri[6], ent_sq2[6], ent_sq1[6]};
            // An ungated entry keeps the previous note, so effects do not glitch.
            if (ent_sq1[6]) note_sq1 <= ent_sq1[5:0];
            if (ent_sq2[6]) note_sq2 <= ent_sq2[5:0];
            if (ent_tri[6]) note_tri <= ent_tri[5:0];
         end
      end
   end

   // Free-running note clock. It keeps running in every state.
   always_ff @(posedge clk50mhz or negedge rst_n) begin
      if (!rst_n) begin
         nclk_cnt <= '0;
         note_clk <= 1'b0;
      end else if (nclk_cnt == NCLK_LAST) begin
         nclk_cnt <= '0;
         note_clk <= ~note_clk;
      end else begin
         nclk_cnt <= nclk_cnt + 1'b1;
      end
   end

   assign playing = (state == PLAYING);
   // Mute is applied combinationally, so it takes effect with zero latency.
   assign en_sq1  = playing & gate[0] & ~mute[0];
   assign en_sq2  = playing & gate[1] & ~mute[1];
   assign en_tri  = playing & gate[2] & ~mute[2];

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer
// Directed bench for step_sequencer with TICK_DIV=4 and NOTE_CLK_DIV=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_step_sequencer;

   logic       clk50mhz = 1'b0;
   logic       rst_n    = 1'b0;
   logic       play = 1'b0, stop = 1'b0, restart = 1'b0;
   logic [3:0] seq_len = 4'd0;
   logic [2:0] mute = 3'd0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_step = 4'd0;
   logic [1:0] wr_ch = 2'd0;
   logic       wr_gate = 1'b0;
   logic [5:0] wr_note = 6'd0;
   logic [5:0] note_sq1, note_sq2, note_tri;
   logic       en_sq1, en_sq2, en_tri;
   logic [3:0] step_idx;
   logic       step_pulse, beat_led, note_clk, playing;

   int checks   = 0;
   int failures = 0;

   // Expected step sequence for seq_len=2: steps 0,1,2, then a wrap to 0.
   int exp_idx  [4] = '{0, 1, 2, 0};
   int exp_note [4] = '{41, 41, 46, 41};
   int exp_en   [4] = '{1, 0, 1, 1};

   step_sequencer #(.TICK_DIV(4), .NOTE_CLK_DIV(3)) dut (
      .clk50mhz(clk50mhz), .rst_n(rst_n), .play(play), .stop(stop),
      .restart(restart), .seq_len(seq_len), .mute(mute), .wr_en(wr_en),
      .wr_step(wr_step), .wr_ch(wr_ch), .wr_gate(wr_gate), .wr_note(wr_note),
      .note_sq1(note_sq1), .note_sq2(note_sq2), .note_tri(note_tri),
      .en_sq1(en_sq1), .en_sq2(en_sq2), .en_tri(en_tri),
      .step_idx(step_idx), .step_pulse(step_pulse), .beat_led(beat_led),
      .note_clk(note_clk), .playing(playing)
   );

   always #5 clk50mhz = ~clk50mhz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk50mhz);
         #1;
      end
   endtask

   task automatic write_entry(input logic [3:0] s, input logic [1:0] c,
                              input logic g, input logic [5:0] n);
      wr_en = 1'b1; wr_step = s; wr_ch = c; wr_gate = g; wr_note = n;
      tick_n(1);
      wr_en = 1'b0;
   endtask

   initial begin
      // Reset, then idle
      tick_n(2);
      check("rst_notes", {note_sq1, note_sq2, note_tri}, 0);
      check("rst_en", {en_sq1, en_sq2, en_tri}, 0);
      check("rst_misc", {step_idx, step_pulse, beat_led, note_clk, playing}, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick_n(1);
         check("idle_note_clk", note_clk, (k / 3) % 2);
         check("idle_step", {step_idx, step_pulse, playing}, 0);
      end

      // Pattern, then play
      write_entry(4'd0, 2'd0, 1'b1, 6'd41);
      write_entry(4'd1, 2'd0, 1'b0, 6'd5);
      write_entry(4'd2, 2'd0, 1'b1, 6'd46);
      write_entry(4'd1, 2'd1, 1'b1, 6'd33);
      write_entry(4'd3, 2'd3, 1'b1, 6'd63);   // wr_ch=3 must be ignored
      seq_len = 4'd2;
      play = 1'b1;
      tick_n(1);
      play = 1'b0;
      check("play_first_note", note_sq1, 41);
      check("play_first_en", en_sq1, 1);
      check("play_first_pulse", step_pulse, 1);
      check("play_first_beat", beat_led, 1);
      check("play_playing", playing, 1);
      check("play_sq2_idle", {en_sq2, note_sq2}, 0);
      for (int c = 1; c <= 12; c++) begin
         tick_n(1);
         check("seq_idx", step_idx, exp_idx[c / 4]);
         check("seq_note", note_sq1, exp_note[c / 4]);
         check("seq_en", en_sq1, exp_en[c / 4]);
         check("seq_pulse", step_pulse, (c % 4 == 0) ? 1 : 0);
         check("seq_beat", beat_led, ((c / 4) % 2 == 0) ? 1 : 0);
      end

      // Stop during step 1, then resume
      tick_n(5);
      check("pre_stop_idx", step_idx, 1);
      check("pre_stop_en_sq2", en_sq2, 1);
      stop = 1'b1;
      tick_n(1);
      stop = 1'b0;
      check("stop_en_sq2", en_sq2, 0);
      check("stop_playing", playing, 0);
      check("stop_idx", step_idx, 1);
      check("stop_note_sq2", note_sq2, 33);
      tick_n(10);
      check("paused_idx", step_idx, 1);
      check("paused_pulse", step_pulse, 0);
      play = 1'b1;
      tick_n(1);
      play = 1'b0;
      check("resume_pulse", step_pulse, 1);
      check("resume_idx", step_idx, 1);
      check("resume_en_sq2", en_sq2, 1);
      tick_n(3);
      check("resume_hold_idx", step_idx, 1);
      check("resume_hold_pulse", step_pulse, 0);
      tick_n(1);
      check("resume_adv_pulse", step_pulse, 1);
      check("resume_adv_idx", step_idx, 2);
      check("resume_adv_note", note_sq1, 46);
      check("resume_sq2_held", {en_sq2, note_sq2}, {1'b0, 6'd33});

      // stop together with play stays STOPPED; restart overrides advance
      stop = 1'b1;
      tick_n(1);
      play = 1'b1;
      tick_n(1);
      play = 1'b0; stop = 1'b0;
      check("stop_play_playing", playing, 0);
      check("stop_play_pulse", step_pulse, 0);
      seq_len = 4'd3;
      play = 1'b1;
      tick_n(1);
      play = 1'b0;
      check("replay_idx", step_idx, 2);
      check("replay_pulse", step_pulse, 1);
      tick_n(3);
      restart = 1'b1;
      tick_n(1);
      restart = 1'b0;
      check("restart_idx", step_idx, 0);
      check("restart_pulse", step_pulse, 1);
      check("restart_note", note_sq1, 41);

      // Write to step 0 on the same edge it reloads
      seq_len = 4'd2;
      tick_n(11);
      write_entry(4'd0, 2'd0, 1'b1, 6'd50);
      check("coll_idx", step_idx, 0);
      check("coll_pulse", step_pulse, 1);
      check("coll_old_note", note_sq1, 41);
      tick_n(12);
      check("coll_next_idx", step_idx, 0);
      check("coll_new_note", note_sq1, 50);

      // Mute on the triangle channel
      write_entry(4'd1, 2'd2, 1'b1, 6'd22);
      write_entry(4'd2, 2'd2, 1'b1, 6'd30);
      tick_n(2);
      check("tri_idx", step_idx, 1);
      check("tri_note", note_tri, 22);
      check("tri_en", en_tri, 1);
      mute = 3'b100;
      #1;
      check("mute_en_tri", en_tri, 0);
      check("mute_en_sq2", en_sq2, 1);
      tick_n(4);
      check("muted_note_tri", note_tri, 30);
      check("muted_en_tri", en_tri, 0);
      check("muted_en_sq1", en_sq1, 1);
      mute = 3'b000;
      #1;
      check("unmute_en_tri", en_tri, 1);

      // Asynchronous reset mid-play clears everything, including the pattern
      rst_n = 1'b0;
      #1;
      check("arst_playing", playing, 0);
      check("arst_notes", {note_sq1, note_sq2, note_tri}, 0);
      check("arst_misc", {step_idx, en_sq1, en_sq2, en_tri, beat_led, note_clk}, 0);
      #3;
      rst_n = 1'b1;
      tick_n(1);
      play = 1'b1;
      tick_n(1);
      play = 1'b0;
      check("arst_replay_pulse", step_pulse, 1);
      check("arst_mem_cleared", {en_sq1, note_sq1}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
